hex_display_ctrl: RTL



---
 rtl/hex_display_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/hex_display_ctrl.sv
// Binary-to-7-segment display driver: sequential double-dabble BCD conversion or raw hex,
// with leading-zero blanking, decimal points and overflow dashes. Optional macro HEXDISP_PENDING_EN.
module hex_display_ctrl #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  logic                  CLK_50,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      value,
    input  logic                  load,
    input  logic                  mode_hex,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     dp,
    output logic                  busy,
    output logic                  ovf,
    output logic [8*DIGITS-1:0]   hex
);
    localparam int NW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
            4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
            4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
            4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
        endcase
    endfunction

    // Add-3 correction applied to every BCD nibble before each shift
    function automatic logic [NW-1:0] dabble_adj(input logic [NW-1:0] b);
        logic [NW-1:0] r;
        r = b;
        for (int d = 0; d < DIGITS; d++)
            if (b[4*d +: 4] >= 4'd5) r[4*d +: 4] = b[4*d +: 4] + 4'd3;
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [BIN_W-1:0]   val_q;
    logic               mode_q;
    logic               blz_q;
    logic [DIGITS-1:0]  dp_q;
    logic               ovf_q;
    logic [NW-1:0]      bcd;
    logic [BIN_W-1:0]   bin;
    logic [NW-1:0]      bcd_adj;
    logic [NW-1:0]      digits;
    logic               ovf_dec;
    logic [8*DIGITS-1:0] hex_next;

    logic               start;
    logic [BIN_W-1:0]   st_val;
    logic               st_mode;
    logic               st_blz;
    logic [DIGITS-1:0]  st_dp;

`ifdef HEXDISP_PENDING_EN
    logic               pend_vld;
    logic [BIN_W-1:0]   pend_val;
    logic               pend_mode;
    logic               pend_blz;
    logic [DIGITS-1:0]  pend_dp;

    // A fresh load in IDLE is newer than anything parked in the slot
    assign start   = (state == IDLE) && (load || pend_vld);
    assign st_val  = load ? value    : pend_val;
    assign st_mode = load ? mode_hex : pend_mode;
    assign st_blz  = load ? blank_lz : pend_blz;
    assign st_dp   = load ? dp       : pend_dp;
`else
    assign start   = (state == IDLE) && load;
    assign st_val  = value;
    assign st_mode = mode_hex;
    assign st_blz  = blank_lz;
    assign st_dp   = dp;
`endif

    assign bcd_adj = dabble_adj(bcd);
    assign digits  = mode_q ? NW'(val_q) : bcd;
    assign ovf_dec = ovf_q && !mode_q;

    always_comb begin
        logic       zero_run;
        logic [7:0] seg;
        zero_run = 1'b1;
        seg      = 8'hFF;
        hex_next = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (digits[4*i +: 4] == 4'd0);
            if (ovf_dec)
                seg = 8'hBF;
            else if (blz_q && zero_run && (i > 0))
                seg = 8'hFF;
            else
                seg = seg7(digits[4*i +: 4]);
            if (dp_q[i]) seg[7] = 1'b0;
            hex_next[8*i +: 8] = seg;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            ovf   <= 1'b0;
            hex   <= '1;
            cnt   <= '0;
`ifdef HEXDISP_PENDING_EN
            pend_vld <= 1'b0;
`endif
        end else begin
`ifdef HEXDISP_PENDING_EN
            if (load && busy) begin
                pend_vld  <= 1'b1;
                pend_val  <= value;
                pend_mode <= mode_hex;
                pend_blz  <= blank_lz;
                pend_dp   <= dp;
            end
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        val_q  <= st_val;
                        mode_q <= st_mode;
                        blz_q  <= st_blz;
                        dp_q   <= st_dp;
                        busy   <= 1'b1;
`ifdef HEXDISP_PENDING_EN
                        pend_vld <= 1'b0;
`endif
                        if (st_mode) begin
                            state <= UPDATE;
                        end else begin
                            bcd   <= '0;
                            bin   <= st_val;
                            ovf_q <= (64'(st_val) > DEC_MAX);
                            cnt   <= '0;
                            state <= CONV;
                        end
                    end
                end
                CONV: begin
                    bcd <= {bcd_adj[NW-2:0], bin[BIN_W-1]};
                    bin <= bin << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(BIN_W - 1)) state <= UPDATE;
                end
                UPDATE: begin
                    hex   <= hex_next;
                    ovf   <= ovf_dec;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
